// File: rtl/fifo_wr_arbiter_if.sv
// Bundle between two write requesters, the arbiter and the FIFO write port.
// slave = arbiter side, master = requesters + FIFO side.
interface fifo_wr_arbiter_if #(
  parameter int DATA_W = 8
);
  logic [1:0]             req_valid;
  logic [1:0][DATA_W-1:0] req_data;
  logic [1:0]             req_ready;
  logic                   lleno;
  logic                   casi_lleno;
  logic                   wr_en;
  logic [DATA_W-1:0]      data_in;
  logic [1:0]             grant;
  logic [7:0]             drop_cnt;

  modport master (
    output req_valid, req_data, lleno, casi_lleno,
    input  req_ready, wr_en, data_in, grant, drop_cnt
  );

  modport slave (
    input  req_valid, req_data, lleno, casi_lleno,
    output req_ready, wr_en, data_in, grant, drop_cnt
  );
endinterface

// File: rtl/fifo_wr_arbiter.sv
// Two-requester round-robin arbiter feeding one FIFO write port, with a
// per-owner burst limit, full/almost-full back-pressure and a stall counter.
module fifo_wr_arbiter #(
  parameter int DATA_W = 8,
  parameter int BURST  = 4
) (
  input  logic             clk,
  input  logic             rst,
  fifo_wr_arbiter_if.slave bus
);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    OWN0 = 2'd1,
    OWN1 = 2'd2
  } state_t;

  localparam logic [3:0] BC_LAST = 4'(BURST - 1);

  state_t            state_q, state_d;
  logic              rr_q, rr_d;
  logic [3:0]        bc_q, bc_d;
  logic              wr_en_q, wr_en_d;
  logic [DATA_W-1:0] data_in_q, data_in_d;
  logic [7:0]        drop_cnt_q, drop_cnt_d;

  logic own_idx;
  logic other_idx;
  logic owner_valid;
  logic accept;
  logic stall;
  logic owner_exit;

  always_comb begin
    own_idx     = (state_q == OWN1);
    other_idx   = ~own_idx;
    owner_valid = (state_q != IDLE) && bus.req_valid[own_idx];
    // With one slot left, the write already in flight would take it.
    accept      = owner_valid && !bus.lleno && !(bus.casi_lleno && wr_en_q);
    stall       = owner_valid && !accept;
    owner_exit  = (state_q != IDLE) &&
                  ((accept && (bc_q == BC_LAST)) || !owner_valid);
  end

  always_comb begin
    state_d = state_q;
    rr_d    = rr_q;
    bc_d    = bc_q;
    case (state_q)
      IDLE: begin
        bc_d = 4'd0;
        case (bus.req_valid)
          2'b01:   state_d = OWN0;
          2'b10:   state_d = OWN1;
          2'b11:   state_d = rr_q ? OWN1 : OWN0;
          default: state_d = IDLE;
        endcase
      end
      OWN0, OWN1: begin
        if (accept) begin
          bc_d = bc_q + 4'd1;
        end
        if (owner_exit) begin
          rr_d = other_idx;
          bc_d = 4'd0;
          if (bus.req_valid[other_idx]) begin
            state_d = other_idx ? OWN1 : OWN0;
          end else begin
            state_d = IDLE;
          end
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_comb begin
    wr_en_d    = accept;
    data_in_d  = accept ? bus.req_data[own_idx] : data_in_q;
    drop_cnt_d = drop_cnt_q;
    if (stall && (drop_cnt_q != 8'hFF)) begin
      drop_cnt_d = drop_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q    <= IDLE;
      rr_q       <= 1'b0;
      bc_q       <= 4'd0;
      wr_en_q    <= 1'b0;
      data_in_q  <= '0;
      drop_cnt_q <= 8'd0;
    end else begin
      state_q    <= state_d;
      rr_q       <= rr_d;
      bc_q       <= bc_d;
      wr_en_q    <= wr_en_d;
      data_in_q  <= data_in_d;
      drop_cnt_q <= drop_cnt_d;
    end
  end

  assign bus.req_ready = {accept && own_idx, accept && !own_idx};
  assign bus.grant     = {state_q == OWN1, state_q == OWN0};
  assign bus.wr_en     = wr_en_q;
  assign bus.data_in   = data_in_q;
  assign bus.drop_cnt  = drop_cnt_q;

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Directed bench for fifo_wr_arbiter: requester source queues, a write
// scoreboard, and ordering/back-pressure rules checked every cycle.
module tb_fifo_wr_arbiter;

  localparam int DATA_W = 8;
  localparam int BURST  = 4;

  logic clk = 1'b0;
  logic rst = 1'b0;
  always #5 clk = ~clk;

  fifo_wr_arbiter_if #(.DATA_W(DATA_W)) bus ();

  fifo_wr_arbiter #(.DATA_W(DATA_W), .BURST(BURST)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int errors = 0;
  int checks = 0;

  logic [7:0] src0[$];
  logic [7:0] src1[$];
  logic [7:0] exp_q[$];

  bit lleno_set, casi_set;
  bit hs0, hs1;
  bit prev_lleno, prev_casi, prev_wr;
  int cyc, first_wr, last_wr, wr_count;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] expv);
    checks++;
    assert (obs === expv) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, expv);
    end
  endtask

  task automatic begin_test();
    first_wr = -1;
    last_wr  = -1;
    wr_count = 0;
  endtask

  // One clock: update inputs just after the edge, sample outputs mid-cycle.
  task automatic tick();
    logic [31:0] expw;
    @(posedge clk);
    #1;
    if (hs0 && src0.size() > 0) void'(src0.pop_front());
    if (hs1 && src1.size() > 0) void'(src1.pop_front());
    bus.lleno          = lleno_set;
    bus.casi_lleno     = casi_set;
    bus.req_valid[0]   = (src0.size() > 0);
    bus.req_data[0]    = (src0.size() > 0) ? src0[0] : 8'h00;
    bus.req_valid[1]   = (src1.size() > 0);
    bus.req_data[1]    = (src1.size() > 0) ? src1[0] : 8'h00;
    @(negedge clk);
    cyc++;
    hs0 = bus.req_valid[0] && bus.req_ready[0];
    hs1 = bus.req_valid[1] && bus.req_ready[1];
    check("ready_within_grant", 32'(bus.req_ready & ~bus.grant), 32'h0);
    if (bus.wr_en === 1'b1) begin
      wr_count++;
      if (first_wr < 0) first_wr = cyc;
      last_wr = cyc;
      expw = (exp_q.size() > 0) ? 32'(exp_q.pop_front()) : 32'hDEAD;
      check("wr_data", 32'(bus.data_in), expw);
      check("wr_after_lleno", 32'(prev_lleno), 32'h0);
      check("wr_after_casi_and_wr", 32'(prev_casi & prev_wr), 32'h0);
    end
    prev_lleno = bus.lleno;
    prev_casi  = bus.casi_lleno;
    prev_wr    = bus.wr_en;
    $display("cyc=%0d grant=%b ready=%b wr_en=%b data_in=%02h drop=%0d",
             cyc, bus.grant, bus.req_ready, bus.wr_en, bus.data_in, bus.drop_cnt);
  endtask

  task automatic reset_seq();
    rst = 1'b0;
    #1;
    check("rst_grant", 32'(bus.grant), 32'h0);
    check("rst_ready", 32'(bus.req_ready), 32'h0);
    check("rst_wr_en", 32'(bus.wr_en), 32'h0);
    check("rst_data_in", 32'(bus.data_in), 32'h0);
    check("rst_drop_cnt", 32'(bus.drop_cnt), 32'h0);
    src0.delete();
    src1.delete();
    exp_q.delete();
    hs0 = 0; hs1 = 0;
    prev_lleno = 0; prev_casi = 0; prev_wr = 0;
    lleno_set = 0; casi_set = 0;
    bus.req_valid  = 2'b00;
    bus.req_data   = '0;
    bus.lleno      = 1'b0;
    bus.casi_lleno = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    rst = 1'b1;
  endtask

  task automatic drain(input string tag, input int budget);
    for (int i = 0; i < budget; i++) begin
      if (src0.size() == 0 && src1.size() == 0 && exp_q.size() == 0 && bus.wr_en !== 1'b1)
        break;
      tick();
    end
    check(tag, 32'(exp_q.size()), 32'h0);
  endtask

  initial begin
    #400000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    cyc = 0;
    bus.req_valid  = 2'b00;
    bus.req_data   = '0;
    bus.lleno      = 1'b0;
    bus.casi_lleno = 1'b0;
    #3;
    reset_seq();

    // Single requester, three words, empty FIFO.
    begin_test();
    src0 = {8'h11, 8'h22, 8'h33};
    exp_q = {8'h11, 8'h22, 8'h33};
    tick();
    check("t1_arb_grant", 32'(bus.grant), 32'h0);
    check("t1_arb_ready", 32'(bus.req_ready), 32'h0);
    tick();
    check("t1_grant", 32'(bus.grant), 32'h1);
    check("t1_ready", 32'(bus.req_ready), 32'h1);
    drain("t1_drain", 20);
    check("t1_idle_grant", 32'(bus.grant), 32'h0);
    check("t1_wr_count", 32'(wr_count), 32'd3);
    check("t1_consecutive", 32'(last_wr - first_wr), 32'd2);

    // Both requesters continuously valid: alternate bursts of BURST words.
    reset_seq();
    begin_test();
    for (int i = 1; i <= 8; i++) begin
      src0.push_back(8'(i));
      src1.push_back(8'(8'h80 + i));
    end
    for (int b = 0; b < 2; b++) begin
      for (int i = 1; i <= BURST; i++) exp_q.push_back(8'(b * BURST + i));
      for (int i = 1; i <= BURST; i++) exp_q.push_back(8'(8'h80 + b * BURST + i));
    end
    drain("t2_drain", 60);
    check("t2_wr_count", 32'(wr_count), 32'd16);
    check("t2_no_gaps", 32'(last_wr - first_wr), 32'd15);

    // req1 owns while the FIFO is full for five cycles.
    reset_seq();
    begin_test();
    src1 = {8'h91, 8'h92, 8'h93};
    exp_q = {8'h91, 8'h92, 8'h93};
    lleno_set = 1;
    tick();
    check("t3_idle_grant", 32'(bus.grant), 32'h0);
    for (int i = 0; i < 5; i++) begin
      tick();
      check("t3_stall_grant", 32'(bus.grant), 32'h2);
      check("t3_stall_ready", 32'(bus.req_ready), 32'h0);
      check("t3_stall_wr_en", 32'(bus.wr_en), 32'h0);
    end
    lleno_set = 0;
    tick();
    check("t3_drop_cnt", 32'(bus.drop_cnt), 32'd5);
    check("t3_resume_ready", 32'(bus.req_ready), 32'h2);
    drain("t3_drain", 20);
    check("t3_wr_count", 32'(wr_count), 32'd3);

    // Almost full: never accept while a write is in flight.
    reset_seq();
    begin_test();
    casi_set = 1;
    src0 = {8'h41, 8'h42, 8'h43, 8'h44};
    exp_q = {8'h41, 8'h42, 8'h43, 8'h44};
    for (int i = 0; i < 12; i++) begin
      tick();
      if (bus.wr_en === 1'b1)
        check("t4_ready_when_casi_wr", 32'(bus.req_ready), 32'h0);
    end
    drain("t4_drain", 10);
    check("t4_wr_count", 32'(wr_count), 32'd4);
    check("t4_alternate", 32'(last_wr - first_wr), 32'd6);
    check("t4_drop_cnt", 32'(bus.drop_cnt), 32'd3);
    casi_set = 0;

    // Reset in the middle of a burst, then restart from IDLE.
    reset_seq();
    begin_test();
    src0 = {8'hA1, 8'hA2, 8'hA3, 8'hA4};
    exp_q = {8'hA1, 8'hA2};
    for (int i = 0; i < 20 && wr_count < 2; i++) tick();
    check("t5_two_written", 32'(wr_count), 32'd2);
    check("t5_exp_empty", 32'(exp_q.size()), 32'h0);
    reset_seq();
    begin_test();
    src0 = {8'hC1, 8'hC2, 8'hC3, 8'hC4};
    src1 = {8'hD1};
    exp_q = {8'hC1, 8'hC2, 8'hC3, 8'hC4, 8'hD1};
    tick();
    check("t5_arb_grant", 32'(bus.grant), 32'h0);
    tick();
    check("t5_regrant", 32'(bus.grant), 32'h1);
    drain("t5_drain", 30);
    check("t5_wr_count", 32'(wr_count), 32'd5);

    // Stall counter saturation.
    reset_seq();
    begin_test();
    lleno_set = 1;
    src1 = {8'hE1};
    exp_q = {8'hE1};
    repeat (300) tick();
    check("t6_drop_sat", 32'(bus.drop_cnt), 32'd255);
    check("t6_grant_held", 32'(bus.grant), 32'h2);
    check("t6_no_write", 32'(wr_count), 32'd0);
    repeat (5) tick();
    check("t6_drop_hold", 32'(bus.drop_cnt), 32'd255);
    lleno_set = 0;
    drain("t6_drain", 10);
    check("t6_wr_count", 32'(wr_count), 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
